// File: rtl/lag_pkg.sv
// lag_pkg: shared types and widths for the lag_meter photodiode latency engine.
//   lag_state_t : measurement FSM states
//   US_W        : width of microsecond counters and results
//   SUM_W       : width of the windowed-average accumulator
package lag_pkg;

    localparam int US_W  = 18;
    localparam int SUM_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        HOLDOFF
    } lag_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: conditions the raw photodiode bit into a clean "lit" level.
// It applies a 2-flop synchronizer, optional polarity inversion and a
// consecutive-cycle debouncer.
// Ports:
//   clk       in  : system clock
//   reset     in  : synchronous, active-high
//   sensor_in in  : raw asynchronous photodiode bit
//   lit       out : debounced "light detected" level
//   lit_rise  out : one-cycle pulse, coincident with lit going 0->1
module sensor_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter bit SENSE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_in,
    output logic lit,
    output logic lit_rise
);

    localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic             sync0;
    logic             sync1;
    logic             lit_raw;
    logic [CNT_W-1:0] stable_cnt;

    // An active-low sensor reports light as 0, so flip it to make lit_raw active-high
    assign lit_raw = sync1 ^ SENSE_LOW;

    // Synchronizer plus debouncer: lit follows lit_raw only after it has
    // disagreed for DEB_CYCLES consecutive cycles. lit_rise is registered
    // together with lit so both change in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            lit        <= 1'b0;
            lit_rise   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync0    <= sensor_in;
            sync1    <= sync0;
            lit_rise <= 1'b0;
            if (lit_raw != lit) begin
                if (stable_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    lit        <= lit_raw;
                    lit_rise   <= lit_raw;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lag_meter.sv
// lag_meter: photodiode latency-measurement engine.
// A trigger from the renderer starts a flash and a microsecond timer. The
// debounced light edge stops the timer, and the latency is published both per
// sample and as an average over a window of 2^AVG_LOG2 samples.
// Ports:
//   clk          in  : system clock
//   reset        in  : synchronous, active-high
//   trigger      in  : one-cycle flash-frame start pulse
//   sensor_in    in  : raw asynchronous photodiode bit
//   flash        out : renderer must draw the white patch
//   busy         out : FSM not in IDLE
//   result_us    out : last measured latency in us (held)
//   result_valid out : pulse when result_us updates
//   timeout      out : pulse on measurement abort
//   fault        out : pulse when a trigger arrives while already lit
//   avg_us       out : mean of the last completed window (held)
//   avg_valid    out : pulse when avg_us updates
//   sample_cnt   out : results accumulated in the current window
module lag_meter
    import lag_pkg::*;
#(
    parameter int US_DIV     = 54,
    parameter int TIMEOUT_US = 200000,
    parameter int HOLDOFF_US = 20000,
    parameter int DEB_CYCLES = 16,
    parameter int AVG_LOG2   = 3,
    parameter bit SENSE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trigger,
    input  logic            sensor_in,
    output logic            flash,
    output logic            busy,
    output logic [US_W-1:0] result_us,
    output logic            result_valid,
    output logic            timeout,
    output logic            fault,
    output logic [US_W-1:0] avg_us,
    output logic            avg_valid,
    output logic [7:0]      sample_cnt
);

    localparam int PRE_W = $clog2(US_DIV);

    lag_state_t        state;
    lag_state_t        state_next;
    logic [PRE_W-1:0]  presc;
    logic [US_W-1:0]   us_cnt;
    logic [SUM_W-1:0]  sum;
    logic              lit;
    logic              lit_rise;
    logic              start;
    logic              capture;
    logic              abort;
    logic              fault_set;
    logic              holdoff_done;
    logic              window_full;

    sensor_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .SENSE_LOW (SENSE_LOW)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .sensor_in(sensor_in),
        .lit      (lit),
        .lit_rise (lit_rise)
    );

    assign holdoff_done = (us_cnt >= US_W'(HOLDOFF_US));
    assign window_full  = (sample_cnt == 8'(1 << AVG_LOG2));

    // Next-state and strobe decode. A light edge is checked before the
    // timeout, so an edge landing on the final microsecond still counts.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        fault_set  = 1'b0;
        flash      = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (trigger) begin
                    if (lit) begin
                        fault_set = 1'b1;
                    end else begin
                        start      = 1'b1;
                        state_next = MEASURE;
                    end
                end
            end
            MEASURE: begin
                flash = 1'b1;
                if (lit_rise) begin
                    capture    = 1'b1;
                    state_next = HOLDOFF;
                end else if (us_cnt == US_W'(TIMEOUT_US)) begin
                    abort      = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (holdoff_done && !lit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, microsecond timebase, result latch and window accumulator.
    // The timebase restarts on both MEASURE and HOLDOFF entry. In HOLDOFF it
    // freezes once the holdoff has elapsed, so an indefinitely lit sensor
    // cannot wrap it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            presc        <= '0;
            us_cnt       <= '0;
            result_us    <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            fault        <= 1'b0;
            sum          <= '0;
            sample_cnt   <= '0;
            avg_us       <= '0;
            avg_valid    <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= capture;
            timeout      <= abort;
            fault        <= fault_set;
            avg_valid    <= 1'b0;

            if (start || capture || abort) begin
                presc  <= '0;
                us_cnt <= '0;
            end else if (state == MEASURE || (state == HOLDOFF && !holdoff_done)) begin
                if (presc == PRE_W'(US_DIV - 1)) begin
                    presc  <= '0;
                    us_cnt <= us_cnt + US_W'(1);
                end else begin
                    presc <= presc + PRE_W'(1);
                end
            end

            if (capture) begin
                result_us <= us_cnt;
            end

            if (window_full) begin
                avg_us     <= US_W'(sum >> AVG_LOG2);
                avg_valid  <= 1'b1;
                sum        <= '0;
                sample_cnt <= '0;
            end else if (capture) begin
                sum        <= sum + SUM_W'(us_cnt);
                sample_cnt <= sample_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lag_meter.sv
// tb_lag_meter: self-checking bench for lag_meter with a small-parameter DUT.
// The reference model works in whole cycles. If the sensor changes right
// after edge n past the trigger, the debounced edge lands n + 2 + DEB_CYCLES
// cycles after the trigger. The latency is that count divided by US_DIV,
// unless it exceeds the timeout budget of TIMEOUT_US * US_DIV cycles.
// Averages are kept as a plain queue of results.
module tb_lag_meter;
    import lag_pkg::*;

    localparam int US_DIV     = 4;
    localparam int TIMEOUT_US = 100;
    localparam int HOLDOFF_US = 5;
    localparam int DEB_CYCLES = 2;
    localparam int AVG_LOG2   = 3;
    localparam int WIN        = 1 << AVG_LOG2;
    localparam int LIMIT      = TIMEOUT_US * US_DIV;

    logic            clk = 1'b0;
    logic            reset;
    logic            trigger;
    logic            sensor_in;
    logic            flash;
    logic            busy;
    logic [US_W-1:0] result_us;
    logic            result_valid;
    logic            timeout;
    logic            fault;
    logic [US_W-1:0] avg_us;
    logic            avg_valid;
    logic [7:0]      sample_cnt;

    int n_checks     = 0;
    int n_fail       = 0;
    int flash_cycles = 0;
    int rv_seen      = 0;
    int to_seen      = 0;
    int av_seen      = 0;
    int window_q[$];
    int last_result  = 0;
    int last_avg     = 0;

    lag_meter #(
        .US_DIV    (US_DIV),
        .TIMEOUT_US(TIMEOUT_US),
        .HOLDOFF_US(HOLDOFF_US),
        .DEB_CYCLES(DEB_CYCLES),
        .AVG_LOG2  (AVG_LOG2),
        .SENSE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .sensor_in   (sensor_in),
        .flash       (flash),
        .busy        (busy),
        .result_us   (result_us),
        .result_valid(result_valid),
        .timeout     (timeout),
        .fault       (fault),
        .avg_us      (avg_us),
        .avg_valid   (avg_valid),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    // Pulse and flash-duration counters, sampled mid-cycle
    always @(negedge clk) begin
        if (flash)        flash_cycles++;
        if (result_valid) rv_seen++;
        if (timeout)      to_seen++;
        if (avg_valid)    av_seen++;
    end

    // One full measurement: trigger, optional 1-cycle glitch, sensor edge after n edges (n < 1: never)
    task automatic run_measure(input int n, input int glitch_at, input string tag);
        int  k, e, e_exp, exp_res, flash0, rv0, to0, sum, exp_avg;
        bit  detect, done, win_done;
        k        = n + 2 + DEB_CYCLES;
        detect   = (n >= 1) && (k <= LIMIT);
        exp_res  = k / US_DIV;
        e_exp    = detect ? k + 1 : LIMIT + 1;
        win_done = 1'b0;
        exp_avg  = last_avg;
        flash0   = flash_cycles;
        rv0      = rv_seen;
        to0      = to_seen;
        trigger  = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        done    = 1'b0;
        e       = 0;
        while (!done && e < 1000) begin
            @(posedge clk); #1;
            e++;
            if (result_valid || timeout) begin
                done = 1'b1;
            end else begin
                if (e == n || e == glitch_at) sensor_in = 1'b0;
                if (glitch_at > 0 && e == glitch_at + 1) sensor_in = 1'b1;
            end
        end
        if (detect) begin
            window_q.push_back(exp_res);
            last_result = exp_res;
            if (window_q.size() == WIN) begin
                sum = 0;
                foreach (window_q[i]) sum += window_q[i];
                exp_avg  = sum / WIN;
                last_avg = exp_avg;
                win_done = 1'b1;
                window_q.delete();
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL %s outcome: no result_valid/timeout within 1000 cycles, required one at cycle %0d", tag, e_exp);
        end else begin
            n_checks++;
            if (e !== e_exp) begin
                n_fail++;
                $display("[TB] FAIL %s outcome_cycle: got %0d, required %0d", tag, e, e_exp);
            end
            n_checks++;
            if (result_valid !== detect || timeout !== !detect) begin
                n_fail++;
                $display("[TB] FAIL %s outcome_kind: result_valid=%b timeout=%b, required result_valid=%b", tag, result_valid, timeout, detect);
            end
        end
        n_checks++;
        if (result_us !== US_W'(last_result)) begin
            n_fail++;
            $display("[TB] FAIL %s result_us: got %0d, required %0d", tag, result_us, last_result);
        end
        @(posedge clk); #1;
        n_checks++;
        if (avg_valid !== win_done || avg_us !== US_W'(exp_avg) || sample_cnt !== 8'(window_q.size())) begin
            n_fail++;
            $display("[TB] FAIL %s window: avg_valid=%b avg_us=%0d sample_cnt=%0d, required %b/%0d/%0d",
                     tag, avg_valid, avg_us, sample_cnt, win_done, exp_avg, window_q.size());
        end
        sensor_in = 1'b1;
        e = 0;
        while (busy && e < 2000) begin
            @(posedge clk); #1;
            e++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s holdoff_exit: busy=%b after 2000 cycles, required 0", tag, busy);
        end
        n_checks++;
        if (flash_cycles - flash0 !== e_exp || rv_seen - rv0 !== int'(detect) || to_seen - to0 !== int'(!detect)) begin
            n_fail++;
            $display("[TB] FAIL %s pulses: flash_cycles=%0d results=%0d timeouts=%0d, required %0d/%0d/%0d",
                     tag, flash_cycles - flash0, rv_seen - rv0, to_seen - to0, e_exp, detect, !detect);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        trigger   = 1'b0;
        sensor_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({flash, busy, result_valid, timeout, fault, avg_valid} !== 6'b0 ||
            result_us !== '0 || avg_us !== '0 || sample_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: flash=%b busy=%b rv=%b to=%b fault=%b av=%b res=%0d avg=%0d cnt=%0d, required all 0",
                     flash, busy, result_valid, timeout, fault, avg_valid, result_us, avg_us, sample_cnt);
        end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || flash !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: busy=%b flash=%b, required 0/0", busy, flash);
        end
    endtask

    task automatic test_average();
        int av0;
        av0 = av_seen;
        for (int i = 1; i <= WIN; i++) begin
            run_measure(i * 40 - 2 - DEB_CYCLES, -1, "average");
        end
        n_checks++;
        if (avg_us !== US_W'(45) || av_seen - av0 !== 1 || sample_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL average_45: avg_us=%0d avg_pulses=%0d sample_cnt=%0d, required 45/1/0", avg_us, av_seen - av0, sample_cnt);
        end
    endtask

    task automatic test_single();
        run_measure(396 - 2 - DEB_CYCLES, -1, "single");
        n_checks++;
        if (result_us !== US_W'(99)) begin
            n_fail++;
            $display("[TB] FAIL single_99: result_us=%0d, required 99", result_us);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] cnt_before;
        cnt_before = sample_cnt;
        run_measure(-1, -1, "timeout");
        n_checks++;
        if (sample_cnt !== cnt_before) begin
            n_fail++;
            $display("[TB] FAIL timeout_cnt: sample_cnt=%0d, required %0d", sample_cnt, cnt_before);
        end
    endtask

    task automatic test_fault();
        sensor_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || flash !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fault_pulse: fault=%b flash=%b busy=%b, required 1/0/0", fault, flash, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fault_single: fault=%b busy=%b, required 0/0", fault, busy);
        end
        sensor_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_glitch_race();
        run_measure(LIMIT - 2 - DEB_CYCLES, 20, "glitch_race");
        n_checks++;
        if (result_us !== US_W'(TIMEOUT_US)) begin
            n_fail++;
            $display("[TB] FAIL race_result: result_us=%0d, required %0d", result_us, TIMEOUT_US);
        end
    endtask

    task automatic test_reset_mid();
        run_measure(50, -1, "pre_reset");
        run_measure(90, -1, "pre_reset");
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (flash !== 1'b0 || busy !== 1'b0 || sample_cnt !== 8'd0 || result_us !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid: flash=%b busy=%b sample_cnt=%0d result_us=%0d, required 0/0/0/0", flash, busy, sample_cnt, result_us);
        end
        reset = 1'b0;
        window_q.delete();
        last_result = 0;
        last_avg    = 0;
        repeat (20) @(posedge clk);
        #1;
        run_measure(100, -1, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_measure(int'($urandom_range(1, 420)), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_average();
        test_single();
        test_timeout();
        test_fault();
        test_glitch_race();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
